// File: rtl/pcnt_seq_pkg.sv
// Shared types for the pcnt configuration sequencer:
// FSM states, status bit positions and slice-count helper.
package pcnt_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_CNTRST = 3'd3,
        ST_RUN    = 3'd4
    } state_e;

    localparam int NSTS       = 4;
    localparam int STS_MATCH0 = 0;
    localparam int STS_MATCH1 = 1;
    localparam int STS_ZERO   = 2;
    localparam int STS_TMO    = 3;

    function automatic int nchunk(input int cfg_w, input int chunk_w);
        return (cfg_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/pcnt_cfg_sequencer_if.sv
// Host-side configuration slice stream: valid/ready handshake
// carrying one CHUNK_W slice plus an end-of-word marker.
interface pcnt_cfg_sequencer_if #(
    parameter int CHUNK_W = 16
) ();

    logic               valid;
    logic               ready;
    logic               last;
    logic [CHUNK_W-1:0] data;

    modport master (
        output valid,
        output last,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  last,
        input  data,
        output ready
    );

endinterface

// File: rtl/pcnt_evt_capture.sv
// Registers the pcnt tile flags, detects rising edges during a run,
// keeps sticky status bits and the registered interrupt.
module pcnt_evt_capture
    import pcnt_seq_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            run_i,
    input  logic [2:0]      evt_i,
    input  logic            tmo_set_i,
    input  logic [NSTS-1:0] clr_i,
    output logic [2:0]      edge_o,
    output logic [NSTS-1:0] status_o,
    output logic            irq_o
);

    logic [2:0]      in_q;
    logic [2:0]      prev_q;
    logic [NSTS-1:0] status_q;
    logic [NSTS-1:0] status_d;
    logic [NSTS-1:0] set;
    logic            irq_q;

    assign edge_o = run_i ? (in_q & ~prev_q) : 3'b000;

    // Set has priority over a simultaneous write-1-to-clear.
    always_comb begin
        set             = '0;
        set[STS_MATCH0] = edge_o[0];
        set[STS_MATCH1] = edge_o[1];
        set[STS_ZERO]   = edge_o[2];
        set[STS_TMO]    = tmo_set_i;
        status_d        = (status_q & ~clr_i) | set;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            in_q     <= '0;
            prev_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            in_q     <= evt_i;
            prev_q   <= in_q;
            status_q <= status_d;
            irq_q    <= |status_q;
        end
    end

    assign status_o = status_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/pcnt_cfg_sequencer.sv
// pcnt tile controller: sliced config load, commit, counter reset, run.
// Optional run watchdog is built when PCNT_SEQ_TIMEOUT_EN is defined.
module pcnt_cfg_sequencer
    import pcnt_seq_pkg::*;
#(
    parameter int CFG_W   = 107,
    parameter int CHUNK_W = 16,
    parameter int RST_CYC = 2,
    parameter int TMO_W   = 16
) (
    input  logic                 pcnt_clk_i,
    input  logic                 pcnt_rst_n_i,
    pcnt_cfg_sequencer_if.slave  cfg,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NSTS-1:0]      status_clr_i,
    input  logic [TMO_W-1:0]     tmo_cycles_i,
    output logic [CFG_W-1:0]     mem_out_o,
    output logic [CFG_W-1:0]     mem_outb_o,
    output logic                 pcnt_rst_o,
    output logic                 pcnt_stop_o,
    input  logic                 pcnt_match0_i,
    input  logic                 pcnt_match1_i,
    input  logic                 pcnt_zero_i,
    output logic [NSTS-1:0]      status_o,
    output logic                 irq_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int NCHUNK = nchunk(CFG_W, CHUNK_W);
    localparam int CNT_W  = $clog2(NCHUNK + 1);
    localparam int RCW    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);
    localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYC - 1);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   idx;
    logic [CFG_W-1:0]   shadow_q;
    logic [CFG_W-1:0]   shadow_d;
    logic [CFG_W-1:0]   shadow_wr;
    logic [CFG_W-1:0]   mem_q;
    logic [CFG_W-1:0]   mem_d;
    logic [RCW-1:0]     rcnt_q;
    logic [RCW-1:0]     rcnt_d;
    logic               cfg_ok_q;
    logic               cfg_ok_d;
    logic               err_q;
    logic               err_d;
    logic               ready_q;
    logic               stop_q;
    logic               prst_q;
    logic [CHUNK_W-1:0] cfg_data;
    logic               accept;
    logic               bad_last;
    logic               tmo_hit;
    logic [2:0]         evt_edge;

    assign cfg_data = cfg.data;
    assign accept   = cfg.valid && ready_q;
    assign idx      = (state_q == ST_LOAD) ? count_q : '0;
    assign bad_last = cfg.last ? (idx != LAST_IDX)
                               : (idx == LAST_IDX);

    // Bits of the final slice beyond CFG_W simply have no home.
    always_comb begin
        shadow_wr = shadow_q;
        for (int b = 0; b < CFG_W; b++) begin
            if (b / CHUNK_W == int'(idx)) begin
                shadow_wr[b] = cfg_data[b % CHUNK_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        mem_d    = mem_q;
        cfg_ok_d = cfg_ok_q;
        err_d    = err_q;
        rcnt_d   = rcnt_q;
        unique case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (state_q == ST_LOAD && abort_i) begin
                    state_d  = ST_IDLE;
                    shadow_d = '0;
                    count_d  = '0;
                end else if (accept) begin
                    if (bad_last) begin
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                        shadow_d = '0;
                        count_d  = '0;
                    end else if (cfg.last) begin
                        shadow_d = shadow_wr;
                        count_d  = '0;
                        state_d  = ST_COMMIT;
                    end else begin
                        shadow_d = shadow_wr;
                        count_d  = idx + 1'b1;
                        state_d  = ST_LOAD;
                    end
                end else if (state_q == ST_IDLE && start_i) begin
                    if (cfg_ok_q) begin
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                mem_d    = shadow_q;
                cfg_ok_d = 1'b1;
                rcnt_d   = '0;
                state_d  = ST_CNTRST;
            end
            ST_CNTRST: begin
                if (rcnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_i || tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tile controls are registered from the next state so that the
    // reset values (tile held in reset/stop) are visible right after reset.
    always_ff @(posedge pcnt_clk_i) begin
        if (!pcnt_rst_n_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            mem_q    <= '0;
            rcnt_q   <= '0;
            cfg_ok_q <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            stop_q   <= 1'b1;
            prst_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            mem_q    <= mem_d;
            rcnt_q   <= rcnt_d;
            cfg_ok_q <= cfg_ok_d;
            err_q    <= err_d;
            ready_q  <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
            stop_q   <= (state_d != ST_RUN);
            prst_q   <= (state_d == ST_CNTRST);
        end
    end

`ifdef PCNT_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic [TMO_W-1:0] tmo_inc;

    assign tmo_inc = tmo_q + 1'b1;

    // Counter is zero outside RUN and on every edge, so each run
    // and each event starts a fresh interval.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (state_q == ST_RUN && evt_edge == 3'b000) begin
            tmo_d   = tmo_inc;
            tmo_hit = (tmo_cycles_i != '0) && (tmo_inc == tmo_cycles_i);
        end
    end

    always_ff @(posedge pcnt_clk_i) begin
        if (!pcnt_rst_n_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^{tmo_cycles_i, evt_edge};
`endif

    pcnt_evt_capture u_evt (
        .clk_i     (pcnt_clk_i),
        .rst_n_i   (pcnt_rst_n_i),
        .run_i     (state_q == ST_RUN),
        .evt_i     ({pcnt_zero_i, pcnt_match1_i, pcnt_match0_i}),
        .tmo_set_i (tmo_hit),
        .clr_i     (status_clr_i),
        .edge_o    (evt_edge),
        .status_o  (status_o),
        .irq_o     (irq_o)
    );

    assign cfg.ready   = ready_q;
    assign mem_out_o   = mem_q;
    assign mem_outb_o  = ~mem_q;
    assign pcnt_rst_o  = prst_q;
    assign pcnt_stop_o = stop_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_pcnt_cfg_sequencer.sv
// Scoreboard bench for pcnt_cfg_sequencer: load, errors, run events,
// abort, watchdog (PCNT_SEQ_TIMEOUT_EN) and mid-run reset.
module tb_pcnt_cfg_sequencer;

    localparam int CFG_W = 107;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       sclr = '0;
    logic [15:0]      tmo = '0;
    logic [CFG_W-1:0] mem_out;
    logic [CFG_W-1:0] mem_outb;
    logic             prst;
    logic             stop;
    logic             m0 = 1'b0;
    logic             m1 = 1'b0;
    logic             zr = 1'b0;
    logic [3:0]       status;
    logic             irq;
    logic             busy;
    logic             err;

    int n_chk = 0;
    int n_bad = 0;

    logic [CFG_W-1:0] mem_sb[$];
    logic [3:0]       sts_sb[$];
    logic [CFG_W-1:0] cur_cfg;
    logic [CFG_W-1:0] ones;
    logic [CFG_W-1:0] exp_mem;
    logic [3:0]       exp_sts;

    pcnt_cfg_sequencer_if #(.CHUNK_W(16)) cfg_if ();

    pcnt_cfg_sequencer dut (
        .pcnt_clk_i    (clk),
        .pcnt_rst_n_i  (rst_n),
        .cfg           (cfg_if),
        .start_i       (start),
        .abort_i       (abort),
        .status_clr_i  (sclr),
        .tmo_cycles_i  (tmo),
        .mem_out_o     (mem_out),
        .mem_outb_o    (mem_outb),
        .pcnt_rst_o    (prst),
        .pcnt_stop_o   (stop),
        .pcnt_match0_i (m0),
        .pcnt_match1_i (m1),
        .pcnt_zero_i   (zr),
        .status_o      (status),
        .irq_o         (irq),
        .busy_o        (busy),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_slice(input logic [15:0] d, input logic l);
        int n = 0;
        while (cfg_if.ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_chk++;
        if (cfg_if.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_wait: got %b want 1", cfg_if.ready);
        end
        cfg_if.valid = 1'b1;
        cfg_if.data  = d;
        cfg_if.last  = l;
        step();
        cfg_if.valid = 1'b0;
        cfg_if.last  = 1'b0;
    endtask

    task automatic load_word(input logic [111:0] w, input int n,
                             input int last_at);
        for (int i = 0; i < n; i++) begin
            send_slice(w[i*16 +: 16], i == last_at);
        end
    endtask

    task automatic wait_commit();
        int k = 0;
        int hi = 0;
        int first = -1;
        do begin
            step();
            k++;
            if (prst === 1'b1) begin
                hi++;
                if (first < 0) first = k;
            end
        end while (busy === 1'b1 && k < 10);
        n_chk++;
        if (k != 3) begin
            n_bad++;
            $display("FAIL busy_latency: got %0d want 3", k);
        end
        n_chk++;
        if (hi != 2 || first != 1) begin
            n_bad++;
            $display("FAIL prst_pulse: got len=%0d at=%0d want len=2 at=1", hi, first);
        end
        n_chk++;
        if (mem_sb.size() == 0) begin
            n_bad++;
            $display("FAIL mem_sb_empty: got 0 entries want 1");
        end else begin
            exp_mem = mem_sb.pop_front();
            if (mem_out !== exp_mem || mem_outb !== ~exp_mem) begin
                n_bad++;
                $display("FAIL mem_commit: got %h/%h want %h/%h", mem_out, mem_outb, exp_mem, ~exp_mem);
            end
        end
    endtask

    task automatic pop_status(input string nm);
        n_chk++;
        if (sts_sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got empty scoreboard want entry", nm);
        end else begin
            exp_sts = sts_sb.pop_front();
            if (status !== exp_sts) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", nm, status, exp_sts);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_chk++;
        if ({mem_out, mem_outb} !== {{CFG_W{1'b0}}, ones}) begin
            n_bad++;
            $display("FAIL reset_mem: got %h/%h want 0/all-ones", mem_out, mem_outb);
        end
        n_chk++;
        if ({prst, stop, status, irq, err, cfg_if.ready, busy} !== 10'b11_0000_0000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 1100000000", {prst, stop, status, irq, err, cfg_if.ready, busy});
        end
        rst_n = 1'b1;
        step();
        n_chk++;
        if ({cfg_if.ready, prst, stop} !== 3'b101) begin
            n_bad++;
            $display("FAIL idle_ctl: got %b want 101", {cfg_if.ready, prst, stop});
        end
    endtask

    task automatic test_load();
        logic [111:0] w;
        w = {7{16'hA5A5}};
        mem_sb.push_back(w[CFG_W-1:0]);
        cur_cfg = w[CFG_W-1:0];
        load_word(w, 7, 6);
        wait_commit();
        n_chk++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_err: got %b want 0", err);
        end
    endtask

    task automatic test_protocol_err();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_word(r[111:0], 4, 3);
        n_chk++;
        if ({err, busy} !== 2'b10 || mem_out !== cur_cfg) begin
            n_bad++;
            $display("FAIL early_last: got err=%b busy=%b mem=%h want 1 0 %h", err, busy, mem_out, cur_cfg);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        cur_cfg = '0;
        load_word(r[111:0], 7, -1);
        n_chk++;
        if ({err, busy} !== 2'b10 || mem_out !== cur_cfg) begin
            n_bad++;
            $display("FAIL missing_last: got err=%b busy=%b mem=%h want 1 0 0", err, busy, mem_out);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_chk++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_cleared: got %b want 0", err);
        end
        pulse_start();
        n_chk++;
        if ({err, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL start_no_cfg: got %b want 10", {err, busy});
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_run_events();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        cur_cfg = r[CFG_W-1:0];
        mem_sb.push_back(cur_cfg);
        load_word(r[111:0], 7, 6);
        wait_commit();
        pulse_start();
        n_chk++;
        if ({busy, stop} !== 2'b10) begin
            n_bad++;
            $display("FAIL run_entry: got %b want 10", {busy, stop});
        end
        repeat (9) step();
        m0 = 1'b1;
        sts_sb.push_back(4'b0001);
        step();
        m0 = 1'b0;
        n_chk++;
        if (status !== 4'b0000) begin
            n_bad++;
            $display("FAIL m0_early: got %b want 0000", status);
        end
        step();
        pop_status("m0_status");
        n_chk++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_early: got %b want 0", irq);
        end
        step();
        n_chk++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_set: got %b want 1", irq);
        end
        step();
        step();
        m0 = 1'b1;
        step();
        m0 = 1'b0;
        sclr = 4'b0001;
        sts_sb.push_back(4'b0001);
        step();
        sclr = 4'b0000;
        pop_status("set_beats_clr");
        sclr = 4'b0001;
        step();
        sclr = 4'b0000;
        n_chk++;
        if ({status, irq} !== 5'b0000_1) begin
            n_bad++;
            $display("FAIL clr_only: got %b want 00001", {status, irq});
        end
        step();
        n_chk++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_clear: got %b want 0", irq);
        end
        m1 = 1'b1;
        zr = 1'b1;
        sts_sb.push_back(4'b0110);
        step();
        m1 = 1'b0;
        zr = 1'b0;
        step();
        pop_status("m1_zero_status");
        pulse_start();
        n_chk++;
        if ({busy, stop, irq} !== 3'b101) begin
            n_bad++;
            $display("FAIL start_in_run: got %b want 101", {busy, stop, irq});
        end
    endtask

    task automatic test_abort();
        logic [127:0] r;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_chk++;
        if ({stop, busy, status} !== 6'b10_0110) begin
            n_bad++;
            $display("FAIL abort_run: got %b want 100110", {stop, busy, status});
        end
        sclr = 4'hF;
        step();
        sclr = 4'h0;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_word(r[111:0], 3, -1);
        n_chk++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL load_busy: got %b want 1", busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_chk++;
        if ({busy, err} !== 2'b00 || mem_out !== cur_cfg) begin
            n_bad++;
            $display("FAIL abort_load: got busy=%b err=%b mem=%h want 0 0 %h", busy, err, mem_out, cur_cfg);
        end
        pulse_start();
        n_chk++;
        if ({busy, err, stop} !== 3'b100) begin
            n_bad++;
            $display("FAIL cfg_kept: got %b want 100", {busy, err, stop});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_timeout();
        tmo = 16'd50;
        pulse_start();
`ifdef PCNT_SEQ_TIMEOUT_EN
        repeat (49) step();
        n_chk++;
        if ({status[3], stop} !== 2'b00) begin
            n_bad++;
            $display("FAIL tmo_early: got %b want 00", {status[3], stop});
        end
        step();
        n_chk++;
        if ({status[3], stop, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL tmo_fire: got %b want 110", {status[3], stop, busy});
        end
        sclr = 4'h8;
        step();
        sclr = 4'h0;
        tmo = 16'd0;
        pulse_start();
        repeat (120) step();
`else
        repeat (60) step();
`endif
        n_chk++;
        if ({status[3], busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL tmo_off: got %b want 01", {status[3], busy});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_mid_reset();
        pulse_start();
        m0 = 1'b1;
        step();
        m0 = 1'b0;
        repeat (3) step();
        n_chk++;
        if ({status, irq, busy} !== 6'b0001_1_1) begin
            n_bad++;
            $display("FAIL pre_reset: got %b want 000111", {status, irq, busy});
        end
        rst_n = 1'b0;
        step();
        n_chk++;
        if ({mem_out, mem_outb} !== {{CFG_W{1'b0}}, ones}) begin
            n_bad++;
            $display("FAIL midrst_mem: got %h/%h want 0/all-ones", mem_out, mem_outb);
        end
        n_chk++;
        if ({prst, stop, status, irq, err, cfg_if.ready, busy} !== 10'b11_0000_0000) begin
            n_bad++;
            $display("FAIL midrst_ctl: got %b want 1100000000", {prst, stop, status, irq, err, cfg_if.ready, busy});
        end
        rst_n = 1'b1;
        step();
        pulse_start();
        n_chk++;
        if ({err, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL cfg_lost: got %b want 10", {err, busy});
        end
    endtask

    initial begin
        cfg_if.valid = 1'b0;
        cfg_if.last  = 1'b0;
        cfg_if.data  = '0;
        ones    = '1;
        cur_cfg = '0;
        test_reset();
        test_load();
        test_protocol_err();
        test_run_events();
        test_abort();
        test_timeout();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

endmodule
